alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 clk  in  1  rising-edge system clock.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 cmd_valid  in  1  command present.
REQ-004 cmd_ready  out  1  sequencer can accept a command.
REQ-005 cmd_op  in  4  ALU function code G.
REQ-006 cmd_a, cmd_b  in  8 each  operands.
REQ-007 cmd_chain  in  1  1 = use accumulator in place of cmd_a.
REQ-008 clr_sticky  in  1  clears sticky overflow.
REQ-009 alu_G  out  4; alu_A, alu_B  out  8 each  registered drive to external ALU.
REQ-010 alu_result  in  8; alu_V, alu_C  in  1 each  combinational ALU return.
REQ-011 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-012 rsp_result  out  8; rsp_flags  out  4  {V,C,N,Z}.
REQ-013 sticky_v  out  1; busy  out  1 (state != IDLE).

Function
REQ-014 FSM states IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on edge with cmd_valid&&cmd_ready SHALL load alu_G=cmd_op, alu_B=cmd_b, alu_A=(cmd_chain ? acc : cmd_a); go EXEC.
REQ-016 EXEC lasts exactly one cycle (ALU settle); next edge SHALL capture alu_result into rsp_result and acc, compute flags, go RESP.
REQ-017 Latency: rsp_valid SHALL rise on the 2nd edge after acceptance; max throughput one command per 3 cycles.
REQ-018 RESP: rsp_valid=1; rsp_result/rsp_flags SHALL hold stable until edge with rsp_ready=1, then IDLE.
REQ-019 Commands while not IDLE SHALL be ignored (not queued).
REQ-020 Z = (alu_result==0); N = alu_result[7].
REQ-021 For cmd_op[3]=1 (logic ops 8-15) captured V and C SHALL be forced 0; for ops 0-7 taken from alu_V/alu_C unchanged.
REQ-022 Codes 9/11/13/15 SHALL be driven unmodified (ALU aliases them to 8/10/12/14).
REQ-023 sticky_v SHALL set on any capture with V=1 and clear on clr_sticky; simultaneous set and clear: set wins.
REQ-024 alu_G/A/B SHALL hold last command values in RESP and IDLE.
REQ-025 acc SHALL update every capture regardless of cmd_chain.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, cmd_ready 1 after release, rsp_valid 0, rsp_result 0, rsp_flags 0, acc 0, sticky_v 0, alu_G/A/B 0.
REQ-027 Reset during EXEC or RESP SHALL abandon the command with no response.

Structure
REQ-028 Shared package alu_pkg SHALL hold G code constants (PASS_A=0, INC=1, ADD=2, ADD_C=3, ADD_NB=4, SUB=5, DEC=6, PASS_A7=7, AND=8, OR=10, XOR=12, NOT_A=14), flag bit indices (V=3,C=2,N=1,Z=0), FSM state type.
REQ-029 No sub-module; ALU instantiated alongside by parent, bench uses behavioural ALU model.

Verification
REQ-030 op=2, a=0x0A, b=0x0A -> alu_G=2 after accept; rsp_valid 2 edges later, rsp_result=0x14, flags=0000.
REQ-031 op=5, a=0x0A, b=0x0A -> rsp_result=0x00, flags C=1, Z=1, V=0, N=0.
REQ-032 op=2 a=0xFF b=0x0A (result 0x09, C=1), then op=1 cmd_chain=1 -> alu_A=0x09, rsp_result=0x0A.
REQ-033 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_valid/result stable, cmd_ready=0, extra command not executed.
REQ-034 op=12 with model returning C=1,V=1 -> rsp_flags C=0,V=0; op=2 a=0x80 b=0x80 V=1 -> sticky_v=1 until clr_sticky.
REQ-035 rst_n low during EXEC -> rsp_valid never asserts, acc=0, cmd_ready=1 on first cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer and the external ALU it
// drives:
//   - G function codes understood by the ALU (odd logic codes 9/11/13/15 are
//     aliases the ALU folds onto 8/10/12/14 and therefore have no name here)
//   - bit positions inside the 4-bit {V,C,N,Z} flag word
//   - sequencer FSM state type
//   - capture_flags(): builds the response flag word from a raw ALU return
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU function codes
    localparam logic [3:0] PASS_A  = 4'd0;
    localparam logic [3:0] INC     = 4'd1;
    localparam logic [3:0] ADD     = 4'd2;
    localparam logic [3:0] ADD_C   = 4'd3;
    localparam logic [3:0] ADD_NB  = 4'd4;
    localparam logic [3:0] SUB     = 4'd5;
    localparam logic [3:0] DEC     = 4'd6;
    localparam logic [3:0] PASS_A7 = 4'd7;
    localparam logic [3:0] AND     = 4'd8;
    localparam logic [3:0] OR      = 4'd10;
    localparam logic [3:0] XOR     = 4'd12;
    localparam logic [3:0] NOT_A   = 4'd14;

    // Flag word bit positions
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Build {V,C,N,Z} from the ALU return. Logic ops (op[3]=1) carry no
    // meaningful arithmetic status, so V and C are cleared for them whatever
    // the ALU reports.
    function automatic logic [3:0] capture_flags(
        input logic [3:0] op,
        input logic [7:0] result,
        input logic       v,
        input logic       c
    );
        logic [3:0] flags;
        flags = 4'b0000;
        if (op[3]) begin
            flags[FLAG_V] = 1'b0;
            flags[FLAG_C] = 1'b0;
        end else begin
            flags[FLAG_V] = v;
            flags[FLAG_C] = c;
        end
        flags[FLAG_N] = result[7];
        flags[FLAG_Z] = (result == 8'h00);
        return flags;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_chk.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_chk
// Protocol properties for alu_op_sequencer, observed purely from its ports.
// Instantiate next to the sequencer with the same signal names.
//   - cmd_ready and busy are complementary
//   - no response is presented while ready for a new command
//   - a stalled response keeps valid, result and flags stable
//   - ALU drive only changes on an accepted command
//   - response appears exactly on the second edge after acceptance
// -----------------------------------------------------------------------------
module alu_op_sequencer_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       cmd_valid,
    input logic       cmd_ready,
    input logic [3:0] alu_G,
    input logic [7:0] alu_A,
    input logic [7:0] alu_B,
    input logic       rsp_valid,
    input logic       rsp_ready,
    input logic [7:0] rsp_result,
    input logic [3:0] rsp_flags,
    input logic       busy
);

    a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
        cmd_ready != busy)
        else $error("cmd_ready and busy not complementary");

    a_ready_no_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        cmd_ready |-> !rsp_valid)
        else $error("response presented while idle");

    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=>
            (rsp_valid && $stable(rsp_result) && $stable(rsp_flags)))
        else $error("stalled response changed");

    a_drive_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !(cmd_valid && cmd_ready) |=>
            ($stable(alu_G) && $stable(alu_A) && $stable(alu_B)))
        else $error("ALU drive changed without an accepted command");

    a_latency: assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_valid && cmd_ready) |=> !rsp_valid ##1 rsp_valid)
        else $error("response latency wrong");

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Accepts one ALU command at a time, drives it onto an external combinational
// ALU through registered alu_G/alu_A/alu_B, waits one cycle for the ALU to
// settle, captures result and flags, and presents them on a valid/ready
// response port. An 8-bit accumulator holds the last captured result so a
// command can chain on it in place of cmd_a.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_op, cmd_a, cmd_b    function code and operands
//   cmd_chain               1 = use accumulator instead of cmd_a
//   clr_sticky              clears sticky overflow (a same-cycle set wins)
//   alu_G, alu_A, alu_B     registered drive to the external ALU
//   alu_result, alu_V/C     combinational ALU return
//   rsp_valid/rsp_ready     response handshake
//   rsp_result, rsp_flags   captured result and {V,C,N,Z}
//   sticky_v                overflow seen since last clear
//   busy                    sequencer not idle
//
// Timing: accept on edge E0, capture on E1 (rsp_valid high after E1), return
// to idle on the first edge with rsp_ready=1, so at best one command per
// three cycles. Commands offered while busy are dropped, never queued.
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_chain,
    input  logic       clr_sticky,
    output logic [3:0] alu_G,
    output logic [7:0] alu_A,
    output logic [7:0] alu_B,
    input  logic [7:0] alu_result,
    input  logic       alu_V,
    input  logic       alu_C,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic       sticky_v,
    output logic       busy
);

    seq_state_e state_r;
    logic [7:0] acc_r;

    logic       accept_s;
    logic       capture_s;
    logic [7:0] operand_a_s;
    logic [3:0] flags_s;

    // Handshake, capture strobe, A-operand select and flag formation
    always_comb begin
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        operand_a_s = cmd_a;
        flags_s     = capture_flags(alu_G, alu_result, alu_V, alu_C);
        // cmd_ready is a registered copy of "state is IDLE"
        if (cmd_valid && cmd_ready) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == ST_EXEC) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (cmd_chain) begin
            operand_a_s = acc_r;
        end else begin
            operand_a_s = cmd_a;
        end
    end

    // Sequencer FSM with registered handshake, ALU drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 8'h00;
            rsp_flags  <= 4'h0;
            acc_r      <= 8'h00;
            alu_G      <= 4'h0;
            alu_A      <= 8'h00;
            alu_B      <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // Function code is passed through untouched; the ALU
                        // itself folds the odd logic aliases.
                        alu_G     <= cmd_op;
                        alu_A     <= operand_a_s;
                        alu_B     <= cmd_b;
                        state_r   <= ST_EXEC;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // ALU has had one full cycle to settle on alu_G/A/B
                    rsp_result <= alu_result;
                    rsp_flags  <= flags_s;
                    acc_r      <= alu_result;
                    rsp_valid  <= 1'b1;
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_r   <= ST_RESP;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle state
                    state_r   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a capture with V=1 beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= 1'b0;
        end else if (capture_s && flags_s[FLAG_V]) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end else begin
            sticky_v <= sticky_v;
        end
    end

endmodule
